// File: rtl/layer_mapper_stream_pkg.sv
// Shared definitions for the layer mapper stream.
//   MAX_LAYERS_LIM : largest supported layer count
//   CFG_W          : width of the cfg_layers field
//   state_e        : mapper control states (IDLE, FILL, HOLD)
//   split_layers() : total layer count L -> per-codeword layer counts (L0, L1)
package layer_mapper_stream_pkg;

  localparam int MAX_LAYERS_LIM = 8;
  localparam int CFG_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] l0;
    logic [CFG_W-1:0] l1;
  } split_t;

  // Up to four layers are carried by codeword 0 alone; above that codeword 0
  // takes the lower half (rounded down) and codeword 1 the remainder.
  function automatic split_t split_layers(input logic [CFG_W-1:0] l);
    split_t s;
    if (l <= (CFG_W)'(4)) begin
      s.l0 = l;
      s.l1 = '0;
    end else begin
      s.l0 = l >> 1;
      s.l1 = l - (l >> 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/layer_slot_filler.sv
// Per-codeword slot collector.
// Accepts symbols into consecutive slots of one layer vector, tracks whether
// the codeword has delivered its last symbol, and leaves unfilled slots zero.
//   clk, rst_n          : clock, synchronous active-low reset
//   en                  : block is in an accepting state
//   clr_cnt             : vector handed off; clear slot count and slot data
//   clr_last            : frame finished; clear the last-seen flag
//   ln                  : number of slots owned by this codeword
//   in_valid/in_ready/in_last/in_data : symbol handshake
//   xfer                : a symbol is accepted this cycle
//   slots_nxt           : slot contents as they will be after this edge
//   done_nxt            : codeword complete for this vector after this edge
//   last_nxt            : codeword counts as having delivered last
module layer_slot_filler
  import layer_mapper_stream_pkg::*;
#(
  parameter int SYM_W      = 32,
  parameter int MAX_LAYERS = MAX_LAYERS_LIM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr_cnt,
  input  logic                        clr_last,
  input  logic [CFG_W-1:0]            ln,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [SYM_W-1:0]            in_data,
  output logic                        in_ready,
  output logic                        xfer,
  output logic [MAX_LAYERS*SYM_W-1:0] slots_nxt,
  output logic                        done_nxt,
  output logic                        last_nxt
);

  logic [CFG_W-1:0]            count_q, count_d;
  logic                        last_q, last_d;
  logic [MAX_LAYERS*SYM_W-1:0] slots_q, slots_d;

  assign in_ready = en && (count_q < ln) && !last_q;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    slots_d = slots_q;
    // Slots are zeroed at every vector boundary, so an early last simply
    // leaves the remaining slots at zero.
    if (clr_cnt) begin
      count_d = '0;
      slots_d = '0;
    end
    if (clr_last) begin
      last_d = 1'b0;
    end
    if (xfer) begin
      for (int j = 0; j < MAX_LAYERS; j++) begin
        if (count_q == (CFG_W)'(j)) begin
          slots_d[j*SYM_W +: SYM_W] = in_data;
        end
      end
      count_d = count_q + (CFG_W)'(1);
      if (in_last) begin
        last_d = 1'b1;
      end
    end
  end

  assign slots_nxt = slots_d;
  assign done_nxt  = (count_d == ln) || last_d;
  // A codeword with no slots never sends last, so it is treated as done.
  assign last_nxt  = last_d || (ln == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      last_q  <= 1'b0;
      slots_q <= '0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
      slots_q <= slots_d;
    end
  end

endmodule

// File: rtl/layer_mapper_stream.sv
// Layer mapper: distributes symbols from two codeword streams onto up to
// MAX_LAYERS output layers and emits one registered layer vector at a time.
//   clk, rst_n                       : clock, synchronous active-low reset
//   cfg_layers                       : layer count L, latched at frame start
//   cw0_valid/ready/last, cw0_data   : codeword-0 symbol stream
//   cw1_valid/ready/last, cw1_data   : codeword-1 symbol stream
//   out_valid/ready/last, out_data   : layer vector stream, layer k at
//                                      out_data[k*SYM_W +: SYM_W]
//   cfg_err                          : sticky illegal-configuration flag
module layer_mapper_stream
  import layer_mapper_stream_pkg::*;
#(
  parameter int SYM_W      = 32,
  parameter int MAX_LAYERS = MAX_LAYERS_LIM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CFG_W-1:0]            cfg_layers,
  input  logic                        cw0_valid,
  output logic                        cw0_ready,
  input  logic                        cw0_last,
  input  logic [SYM_W-1:0]            cw0_data,
  input  logic                        cw1_valid,
  output logic                        cw1_ready,
  input  logic                        cw1_last,
  input  logic [SYM_W-1:0]            cw1_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [MAX_LAYERS*SYM_W-1:0] out_data,
  output logic                        cfg_err
);

  localparam int VEC_W = MAX_LAYERS * SYM_W;

  state_e              state_q, state_d;
  logic [CFG_W-1:0]    l_q, l_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [VEC_W-1:0]    out_data_q, out_data_d;
  logic                cfg_err_q, cfg_err_d;

  logic [CFG_W-1:0]    l_eff;
  split_t              sp;
  logic                cfg_legal;
  logic                en;
  logic                clr_cnt, clr_last;
  logic                xfer0, xfer1;
  logic [VEC_W-1:0]    slots0_nxt, slots1_nxt;
  logic                done0_nxt, done1_nxt;
  logic                last0_nxt, last1_nxt;
  logic [VEC_W-1:0]    vec_nxt;

  assign cfg_legal = (cfg_layers != '0) && (cfg_layers <= (CFG_W)'(MAX_LAYERS));
  // In IDLE the live configuration drives the readies; once a frame has
  // started only the latched value matters.
  assign l_eff     = (state_q == ST_IDLE) ? cfg_layers : l_q;
  assign sp        = split_layers(l_eff);
  assign en        = rst_n && (((state_q == ST_IDLE) && cfg_legal) || (state_q == ST_FILL));

  layer_slot_filler #(.SYM_W(SYM_W), .MAX_LAYERS(MAX_LAYERS)) u_fill0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .clr_last  (clr_last),
    .ln        (sp.l0),
    .in_valid  (cw0_valid),
    .in_last   (cw0_last),
    .in_data   (cw0_data),
    .in_ready  (cw0_ready),
    .xfer      (xfer0),
    .slots_nxt (slots0_nxt),
    .done_nxt  (done0_nxt),
    .last_nxt  (last0_nxt)
  );

  layer_slot_filler #(.SYM_W(SYM_W), .MAX_LAYERS(MAX_LAYERS)) u_fill1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .clr_last  (clr_last),
    .ln        (sp.l1),
    .in_valid  (cw1_valid),
    .in_last   (cw1_last),
    .in_data   (cw1_data),
    .in_ready  (cw1_ready),
    .xfer      (xfer1),
    .slots_nxt (slots1_nxt),
    .done_nxt  (done1_nxt),
    .last_nxt  (last1_nxt)
  );

  // Layers below L0 come from codeword 0, layers L0..L-1 from codeword 1,
  // everything above L stays zero.
  always_comb begin
    vec_nxt = '0;
    for (int k = 0; k < MAX_LAYERS; k++) begin
      if ((CFG_W)'(k) < sp.l0) begin
        vec_nxt[k*SYM_W +: SYM_W] = slots0_nxt[k*SYM_W +: SYM_W];
      end else if ((CFG_W)'(k) < l_eff) begin
        for (int j = 0; j < MAX_LAYERS; j++) begin
          if ((CFG_W)'(j) == ((CFG_W)'(k) - sp.l0)) begin
            vec_nxt[k*SYM_W +: SYM_W] = slots1_nxt[j*SYM_W +: SYM_W];
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cfg_err_d   = cfg_err_q;
    clr_cnt     = 1'b0;
    clr_last    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if ((state_q == ST_IDLE) && !cfg_legal && (cw0_valid || cw1_valid)) begin
          cfg_err_d = 1'b1;
        end
        if ((state_q == ST_IDLE) && (xfer0 || xfer1)) begin
          l_d     = cfg_layers;
          state_d = ST_FILL;
        end
        // Completion can happen on the very first transfer (e.g. L=1).
        if ((xfer0 || xfer1) && done0_nxt && done1_nxt) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          out_last_d  = last0_nxt && last1_nxt;
          out_data_d  = vec_nxt;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          clr_cnt     = 1'b1;
          if (out_last_q) begin
            clr_last = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_layer_mapper_stream.sv
module tb_layer_mapper_stream;

  localparam int SYM_W      = 32;
  localparam int MAX_LAYERS = 8;
  localparam int VEC_W      = SYM_W * MAX_LAYERS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       cfg_layers;
  logic             cw0_valid, cw0_ready, cw0_last;
  logic [SYM_W-1:0] cw0_data;
  logic             cw1_valid, cw1_ready, cw1_last;
  logic [SYM_W-1:0] cw1_data;
  logic             out_valid, out_ready, out_last;
  logic [VEC_W-1:0] out_data;
  logic             cfg_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  layer_mapper_stream #(.SYM_W(SYM_W), .MAX_LAYERS(MAX_LAYERS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_layers (cfg_layers),
    .cw0_valid  (cw0_valid),
    .cw0_ready  (cw0_ready),
    .cw0_last   (cw0_last),
    .cw0_data   (cw0_data),
    .cw1_valid  (cw1_valid),
    .cw1_ready  (cw1_ready),
    .cw1_last   (cw1_last),
    .cw1_data   (cw1_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_data   (out_data),
    .cfg_err    (cfg_err)
  );

  function automatic logic [VEC_W-1:0] vec8(
    input logic [31:0] l7, input logic [31:0] l6, input logic [31:0] l5, input logic [31:0] l4,
    input logic [31:0] l3, input logic [31:0] l2, input logic [31:0] l1, input logic [31:0] l0);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cw0_valid = 1'b0; cw0_last = 1'b0; cw0_data = '0;
    cw1_valid = 1'b0; cw1_last = 1'b0; cw1_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Present a symbol on one or both codewords and wait (bounded) for the
  // handshake edge; returns shortly after the transfer edge.
  task automatic send(input logic v0, input logic [31:0] d0, input logic l0,
                      input logic v1, input logic [31:0] d1, input logic l1,
                      input string tag);
    int guard;
    guard = 0;
    cw0_valid = v0; cw0_data = d0; cw0_last = l0;
    cw1_valid = v1; cw1_data = d1; cw1_last = l1;
    #1;
    while (!((!v0 || cw0_ready) && (!v1 || cw1_ready)) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      compared++;
      mismatched++;
      $error("FAIL %s_timeout: observed no ready after %0d cycles, expected ready", tag, guard);
    end
    @(posedge clk); #1;
    cw0_valid = 1'b0; cw0_last = 1'b0;
    cw1_valid = 1'b0; cw1_last = 1'b0;
    #1;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VEC_W-1:0] held;

    // Reset state
    cfg_layers = 4'd2;
    do_reset();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_out_last", out_last, 1'b0);
    check_vec("rst_out_data", out_data, '0);
    check_bit("rst_cfg_err", cfg_err, 1'b0);
    check_bit("idle_l2_cw0_ready", cw0_ready, 1'b1);
    check_bit("idle_l2_cw1_ready", cw1_ready, 1'b0);
    cfg_layers = 4'd8; #1;
    check_bit("idle_l8_cw1_ready", cw1_ready, 1'b1);
    cfg_layers = 4'd2; #1;

    // L=2, codeword 0 only
    send(1'b1, 32'h00010001, 1'b0, 1'b0, 32'h0, 1'b0, "l2_s0");
    check_bit("l2_fill_cw1_ready", cw1_ready, 1'b0);
    check_bit("l2_fill_out_valid", out_valid, 1'b0);
    send(1'b1, 32'h00020002, 1'b1, 1'b0, 32'h0, 1'b0, "l2_s1");
    check_bit("l2_out_valid", out_valid, 1'b1);
    check_vec("l2_out_data", out_data, vec8(0, 0, 0, 0, 0, 0, 32'h00020002, 32'h00010001));
    check_bit("l2_out_last", out_last, 1'b1);
    check_bit("l2_hold_cw0_ready", cw0_ready, 1'b0);
    check_bit("l2_hold_cw1_ready", cw1_ready, 1'b0);
    handoff();
    check_bit("l2_after_out_valid", out_valid, 1'b0);
    check_bit("l2_after_cw0_ready", cw0_ready, 1'b1);

    // L=8, both codewords in parallel
    cfg_layers = 4'd8;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'hA0000000 + 32'(i), (i == 3), 1'b1, 32'hB0000000 + 32'(i), (i == 3), "l8");
      if (i == 2) check_bit("l8_no_early_valid", out_valid, 1'b0);
    end
    check_bit("l8_out_valid", out_valid, 1'b1);
    check_vec("l8_out_data", out_data,
              vec8(32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000,
                   32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000));
    check_bit("l8_out_last", out_last, 1'b1);
    handoff();

    // L=5: L0=2, L1=3
    cfg_layers = 4'd5;
    send(1'b1, 32'hA0000000, 1'b0, 1'b1, 32'hB0000000, 1'b0, "l5_s0");
    send(1'b1, 32'hA0000001, 1'b1, 1'b1, 32'hB0000001, 1'b0, "l5_s1");
    check_bit("l5_cw0_full_ready", cw0_ready, 1'b0);
    check_bit("l5_cw1_ready", cw1_ready, 1'b1);
    send(1'b0, 32'h0, 1'b0, 1'b1, 32'hB0000002, 1'b1, "l5_s2");
    check_bit("l5_out_valid", out_valid, 1'b1);
    check_vec("l5_out_data", out_data,
              vec8(0, 0, 0, 32'hB0000002, 32'hB0000001, 32'hB0000000, 32'hA0000001, 32'hA0000000));
    check_bit("l5_out_last", out_last, 1'b1);
    handoff();

    // L=4, back-pressure on the output
    cfg_layers = 4'd4;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'hC0000000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, "l4");
    end
    held = vec8(0, 0, 0, 0, 32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000);
    check_bit("l4_out_valid", out_valid, 1'b1);
    check_vec("l4_out_data", out_data, held);
    check_bit("l4_out_last", out_last, 1'b0);
    cfg_layers = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_vec("l4_hold_data", out_data, held);
      check_bit("l4_hold_cw0_ready", cw0_ready, 1'b0);
      check_bit("l4_hold_out_valid", out_valid, 1'b1);
    end
    handoff();
    check_bit("l4_next_out_valid", out_valid, 1'b0);
    check_bit("l4_next_cw0_ready", cw0_ready, 1'b1);
    check_bit("l4_latched_cw1_ready", cw1_ready, 1'b0);

    // Same frame, early last on the 2nd symbol
    send(1'b1, 32'hD0000000, 1'b0, 1'b0, 32'h0, 1'b0, "el_s0");
    send(1'b1, 32'hD0000001, 1'b1, 1'b0, 32'h0, 1'b0, "el_s1");
    check_bit("el_out_valid", out_valid, 1'b1);
    check_vec("el_out_data", out_data, vec8(0, 0, 0, 0, 0, 0, 32'hD0000001, 32'hD0000000));
    check_bit("el_out_last", out_last, 1'b1);
    check_bit("el_hold_cw0_ready", cw0_ready, 1'b0);
    handoff();
    check_bit("el_idle_cw1_ready", cw1_ready, 1'b1);
    check_bit("el_idle_cw0_ready", cw0_ready, 1'b1);

    // Illegal configurations, then recovery
    cfg_layers = 4'd0;
    cw0_valid = 1'b1; cw0_data = 32'hEEEE0000;
    repeat (3) @(posedge clk);
    #1;
    check_bit("cfg0_err", cfg_err, 1'b1);
    check_bit("cfg0_cw0_ready", cw0_ready, 1'b0);
    check_bit("cfg0_cw1_ready", cw1_ready, 1'b0);
    check_bit("cfg0_out_valid", out_valid, 1'b0);
    cfg_layers = 4'd9;
    cw1_valid = 1'b1; cw1_data = 32'hEEEE1111;
    repeat (3) @(posedge clk);
    #1;
    check_bit("cfg9_err", cfg_err, 1'b1);
    check_bit("cfg9_cw0_ready", cw0_ready, 1'b0);
    check_bit("cfg9_cw1_ready", cw1_ready, 1'b0);
    check_bit("cfg9_out_valid", out_valid, 1'b0);
    cw0_valid = 1'b0; cw1_valid = 1'b0;
    cfg_layers = 4'd3; #1;
    check_bit("cfg3_cw0_ready", cw0_ready, 1'b1);
    check_bit("cfg3_cw1_ready", cw1_ready, 1'b0);
    send(1'b1, 32'hE0000000, 1'b0, 1'b0, 32'h0, 1'b0, "cfg3_s0");
    send(1'b1, 32'hE0000001, 1'b0, 1'b0, 32'h0, 1'b0, "cfg3_s1");
    send(1'b1, 32'hE0000002, 1'b1, 1'b0, 32'h0, 1'b0, "cfg3_s2");
    check_bit("cfg3_out_valid", out_valid, 1'b1);
    check_vec("cfg3_out_data", out_data, vec8(0, 0, 0, 0, 0, 32'hE0000002, 32'hE0000001, 32'hE0000000));
    check_bit("cfg3_out_last", out_last, 1'b1);
    check_bit("cfg3_err_sticky", cfg_err, 1'b1);
    handoff();

    // Reset mid-FILL discards the partial vector
    send(1'b1, 32'hF0000000, 1'b0, 1'b0, 32'h0, 1'b0, "mid_s0");
    check_bit("mid_fill_cw0_ready", cw0_ready, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    check_bit("mid_rst_out_last", out_last, 1'b0);
    check_vec("mid_rst_out_data", out_data, '0);
    check_bit("mid_rst_cfg_err", cfg_err, 1'b0);
    check_bit("mid_rst_cw0_ready", cw0_ready, 1'b1);
    send(1'b1, 32'h60000000, 1'b0, 1'b0, 32'h0, 1'b0, "post_s0");
    check_bit("post_no_early_valid", out_valid, 1'b0);
    send(1'b1, 32'h60000001, 1'b0, 1'b0, 32'h0, 1'b0, "post_s1");
    send(1'b1, 32'h60000002, 1'b1, 1'b0, 32'h0, 1'b0, "post_s2");
    check_bit("post_out_valid", out_valid, 1'b1);
    check_vec("post_out_data", out_data, vec8(0, 0, 0, 0, 0, 32'h60000002, 32'h60000001, 32'h60000000));
    check_bit("post_out_last", out_last, 1'b1);
    handoff();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
